spi_slave_xcvr: RTL
===================

SPI_SLAVE_XCVR -- requirements
Module: spi_slave_xcvr

Interface
REQ-001 Parameter WIDTH, default 8, sets the bits per SPI word (range 4..32).
REQ-002 Parameter CPOL, default 0, sets the SPI clock idle level.
REQ-003 Parameter CPHA, default 0: 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-004 Parameter MSB_FIRST, default 1: 1 = MSB shifted first, 0 = LSB shifted first.
REQ-005 Clocking: one clock; reset is synchronous and active-high.
REQ-006 Port clk, input, 1 bit: system clock; all logic runs on its rising edge.
REQ-007 Port rst, input, 1 bit: reset, synchronous to clk, active-high.
REQ-008 Port sclk, input, 1 bit: SPI clock, asynchronous to clk, at most clk/4.
REQ-009 Port cs, input, 1 bit: chip select, active-low, asynchronous to clk.
REQ-010 Port mosi, input, 1 bit: serial data from the master, asynchronous to clk.
REQ-011 Port miso, output, 1 bit: serial data to the master.
REQ-012 Port miso_oe, output, 1 bit: MISO drive enable, high only while the synchronised cs is low.
REQ-013 Port tx_data, input, WIDTH bits: next word to transmit.
REQ-014 Port tx_valid / tx_ready, input / output, 1 bit each: transmit handshake; a word is accepted when both are high in the same clk cycle.
REQ-015 Port rx_data, output, WIDTH bits: last received word.
REQ-016 Port rx_valid / rx_ready, output / input, 1 bit each: receive handshake; rx_valid holds until rx_ready is high in the same cycle.
REQ-017 Port overrun, output, 1 bit: one-cycle pulse when a received word is dropped.
REQ-018 Port frame_err, output, 1 bit: one-cycle pulse when cs rises mid-word.

Function
REQ-019 sclk, cs and mosi SHALL each pass through a 2-flop synchroniser; edges SHALL be detected from the 2nd and 3rd stages.
REQ-020 The state machine SHALL have two states. IDLE goes to ACTIVE on a falling edge of synchronised cs. ACTIVE goes to IDLE on a rising edge of synchronised cs.
REQ-021 The sample edge SHALL be rising when CPOL==CPHA and falling otherwise; the shift edge SHALL be the opposite edge.
REQ-022 On each sample edge in ACTIVE, the synchronised mosi SHALL be shifted into rx_shift, and the bit counter (width clog2(WIDTH)) SHALL increment.
REQ-023 When the bit counter reaches WIDTH-1 on a sample edge, it SHALL wrap to 0, and the completed word SHALL be offered to the receive side in the next clk cycle.
REQ-024 rx_valid SHALL assert no more than 4 clk cycles after the sclk pin edge that completes the word.
REQ-025 Receive buffering:
- If rx_valid is low, or rx_valid and rx_ready are both high in the completion cycle: rx_data is loaded and rx_valid is set.
- Otherwise: the new word is discarded, rx_data is unchanged, and overrun pulses.
REQ-026 Transmit loading:
- tx_ready SHALL be high when the tx holding register is empty.
- An accepted word SHALL be loaded into tx_shift at cs fall and at each word wrap.
- If no word is held at a load point, tx_shift SHALL load all zeros.
REQ-027 Transmit timing:
- CPHA=0: the first bit SHALL be on miso within 3 clk cycles of the cs pin falling; later bits change on shift edges.
- CPHA=1: every bit, including the first, SHALL be presented on a shift edge.
REQ-028 Bit order SHALL follow MSB_FIRST for both rx and tx.
REQ-029 When cs rises with the bit counter non-zero:
- frame_err pulses;
- the counter and rx_shift clear;
- the partial word is discarded;
- the tx holding register is kept.
REQ-030 sclk edges while in IDLE SHALL be ignored.
REQ-031 miso SHALL be 0 when miso_oe is low.

Reset
REQ-032 On rst the block SHALL enter IDLE, with:
- rx_data = 0, rx_valid = 0, tx_ready = 1;
- miso = 0, miso_oe = 0, overrun = 0, frame_err = 0;
- bit counter and shift registers = 0;
- synchroniser flops: sclk stages = CPOL, cs stages = 1, mosi stages = 0.
REQ-033 A reset asserted mid-frame SHALL abort the frame without a frame_err pulse; reception SHALL resume only after a new cs fall.

Structure
REQ-034 A shared package (spi_pkg) SHALL hold the state enumeration (IDLE, ACTIVE) and the mode encoding constants.
REQ-035 The 2-flop synchroniser SHALL be one sub-module, sync2, instantiated three times.

Verification
REQ-036 Mode 0, WIDTH=8: send 0xA5 on mosi while tx_data=0x3C is pre-loaded -> rx_data=0xA5 with one rx_valid; miso carries 0x3C MSB-first.
REQ-037 Mode 3, MSB_FIRST=0: send 0x81 -> rx_data=0x81; LSB sampled first on rising edges.
REQ-038 Two back-to-back words 0x11, 0x22 with rx_ready held low -> rx_data=0x11, overrun pulses once, 0x22 is discarded.
REQ-039 cs rises after 5 bits -> frame_err pulses once, no rx_valid; the next full word 0x5A is received correctly.
REQ-040 No tx word loaded at cs fall -> miso shifts 0x00; tx_ready stays high.
REQ-041 rst asserted after 3 bits -> all outputs at reset values the next cycle; a following full frame 0xF0 is received correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave transceiver: controller states and
// SPI mode encoding ({CPOL, CPHA}).
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

  typedef enum logic [1:0] {
    SPI_MODE0 = 2'b00,
    SPI_MODE1 = 2'b01,
    SPI_MODE2 = 2'b10,
    SPI_MODE3 = 2'b11
  } spi_mode_e;

  // Modes 0 and 3 (CPOL == CPHA) sample on the rising sclk edge.
  function automatic logic sample_on_rise(input spi_mode_e mode);
    return (mode == SPI_MODE0) || (mode == SPI_MODE3);
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for one asynchronous input, with a selectable reset
// value so the synchronised line starts at the signal's idle level.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  assign meta_d = d;
  assign sync_d = meta_q;
  assign q      = sync_q;

  // Two-stage capture of the asynchronous input.
  // NOTE: flops use non-blocking assignments so every stage samples the
  // value from before the clock edge; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

endmodule

// File: rtl/spi_slave_xcvr.sv
// SPI slave transceiver: oversamples sclk/cs/mosi on clk, shifts WIDTH-bit
// words in and out, and exposes valid/ready handshakes on both sides.
module spi_slave_xcvr
  import spi_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CPOL      = 0,
  parameter int CPHA      = 0,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             cs,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             overrun,
  output logic             frame_err
);

  localparam int        CW          = $clog2(WIDTH);
  localparam spi_mode_e MODE        = spi_mode_e'({CPOL[0], CPHA[0]});
  localparam logic      SAMPLE_RISE = sample_on_rise(MODE);

  logic sclk_s, cs_s, mosi_s;

  sync2 #(.RST_VAL(CPOL[0])) u_sync_sclk (.clk(clk), .rst(rst), .d(sclk), .q(sclk_s));
  sync2 #(.RST_VAL(1'b1))    u_sync_cs   (.clk(clk), .rst(rst), .d(cs),   .q(cs_s));
  sync2 #(.RST_VAL(1'b0))    u_sync_mosi (.clk(clk), .rst(rst), .d(mosi), .q(mosi_s));

  spi_state_e       state_q, state_d;
  logic             sclk_dly_q, sclk_dly_d;
  logic             cs_dly_q, cs_dly_d;
  logic [1:0]       settle_q, settle_d;
  logic             armed_q, armed_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [WIDTH-1:0] tx_hold_q, tx_hold_d;
  logic             tx_full_q, tx_full_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             overrun_q, overrun_d;
  logic             frame_err_q, frame_err_d;
  logic             miso_q, miso_d;
  logic             miso_oe_q, miso_oe_d;

  // Edges are seen between the synchroniser output and one extra stage.
  logic sclk_rise, sclk_fall, cs_rise, cs_fall, sample_edge, shift_edge;
  logic [WIDTH-1:0] tx_next;

  assign sclk_rise   = sclk_s & ~sclk_dly_q;
  assign sclk_fall   = ~sclk_s & sclk_dly_q;
  assign cs_rise     = cs_s & ~cs_dly_q;
  assign cs_fall     = ~cs_s & cs_dly_q;
  assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
  assign shift_edge  = SAMPLE_RISE ? sclk_fall : sclk_rise;
  // Word handed to the shifter at a load point; zeros when nothing is held.
  assign tx_next     = tx_full_q ? tx_hold_q : '0;

  function automatic logic tx_head(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] tx_advance(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
  endfunction

  function automatic logic [WIDTH-1:0] rx_insert(input logic [WIDTH-1:0] w, input logic b);
    return (MSB_FIRST != 0) ? {w[WIDTH-2:0], b} : {b, w[WIDTH-1:1]};
  endfunction

  // Next-state logic for the frame controller, shifters and handshakes.
  always_comb begin
    // NOTE: every _d starts from its _q (or a pulse default) so no path through
    // this block leaves a signal unassigned and infers a latch.
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    tx_hold_d   = tx_hold_q;
    tx_full_d   = tx_full_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    miso_d      = miso_q;
    done_d      = 1'b0;
    overrun_d   = 1'b0;
    frame_err_d = 1'b0;
    sclk_dly_d  = sclk_s;
    cs_dly_d    = cs_s;
    // After reset the cs pipeline still holds reset values; only a cs seen
    // high once it has flushed arms the next fall, so a frame interrupted by
    // reset is not picked up halfway through.
    settle_d    = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
    armed_d     = armed_q | ((settle_q == 2'd3) & cs_s);

    case (state_q)
      IDLE: begin
        if (cs_fall && armed_q) begin
          state_d    = ACTIVE;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          tx_full_d  = 1'b0;
          if (CPHA == 0) begin
            // First bit goes out immediately; the first shift edge shows bit 1.
            miso_d     = tx_head(tx_next);
            tx_shift_d = tx_advance(tx_next);
          end else begin
            miso_d     = 1'b0;
            tx_shift_d = tx_next;
          end
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d     = IDLE;
          frame_err_d = (bit_cnt_q != '0);
          bit_cnt_d   = '0;
          rx_shift_d  = '0;
        end else if (sample_edge) begin
          rx_shift_d = rx_insert(rx_shift_q, mosi_s);
          if (bit_cnt_q == CW'(WIDTH - 1)) begin
            bit_cnt_d  = '0;
            done_d     = 1'b1;
            // The shift edge after the wrap presents bit 0 of this word.
            tx_shift_d = tx_next;
            tx_full_d  = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (shift_edge) begin
          miso_d     = tx_head(tx_shift_q);
          tx_shift_d = tx_advance(tx_shift_q);
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) miso_d = 1'b0;
    miso_oe_d = (state_d == ACTIVE);

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
    if (done_q) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = rx_shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    // Accept after the load point so a same-cycle load sees the old holding state.
    if (tx_valid && !tx_full_q) begin
      tx_hold_d = tx_data;
      tx_full_d = 1'b1;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sclk_dly_q  <= CPOL[0];
      cs_dly_q    <= 1'b1;
      settle_q    <= '0;
      armed_q     <= 1'b0;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      tx_hold_q   <= '0;
      tx_full_q   <= 1'b0;
      done_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_dly_q  <= sclk_dly_d;
      cs_dly_q    <= cs_dly_d;
      settle_q    <= settle_d;
      armed_q     <= armed_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      tx_hold_q   <= tx_hold_d;
      tx_full_q   <= tx_full_d;
      done_q      <= done_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
    end
  end

  assign miso      = miso_q;
  assign miso_oe   = miso_oe_q;
  assign tx_ready  = ~tx_full_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule
